// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if
// Bundles every signal of the issue stage except clock and reset:
//   request channel  : in_valid/in_ready handshake with in_op, in_a, in_b, in_cin
//   ALU drive/return : alu_a, alu_b, alu_ctrl, alu_cin out; alu_out, alu_cout back
//   result channel   : out_valid/out_ready handshake with out_result, out_cout,
//                      out_zero, out_err
// Modports:
//   slave  - the sequencer itself
//   master - its environment (requester, ALU and result consumer together)
interface alu_issue_seq_if #(
  parameter int REG_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [REG_WIDTH-1:0] in_a;
  logic [REG_WIDTH-1:0] in_b;
  logic                 in_cin;

  logic [REG_WIDTH-1:0] alu_a;
  logic [REG_WIDTH-1:0] alu_b;
  logic [7:0]           alu_ctrl;
  logic                 alu_cin;
  logic [REG_WIDTH-1:0] alu_out;
  logic                 alu_cout;

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] out_result;
  logic                 out_cout;
  logic                 out_zero;
  logic                 out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, alu_out, alu_cout, out_ready,
    output in_ready, alu_a, alu_b, alu_ctrl, alu_cin,
           out_valid, out_result, out_cout, out_zero, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, alu_out, alu_cout, out_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl, alu_cin,
           out_valid, out_result, out_cout, out_zero, out_err
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq
// Issue/sequencing stage in front of a combinational ALU. It accepts an opcode
// and operands, decodes the opcode into the ALU's 8-bit control word, drives
// the ALU from registers and captures the ALU result into a one-deep output
// slot with its own handshake.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset, clears every flop
//   bus     - alu_issue_seq_if.slave (request, ALU drive/return, result)
// Optional feature macro: ALU_ISSUE_MUL_EN
//   defined   - opcode 0xA is a shift-add multiply built from repeated ALU adds
//   undefined - opcode 0xA is illegal and no multiply logic exists
module alu_issue_seq #(
  parameter int REG_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_issue_seq_if.slave  bus
);

  localparam logic [7:0] CTRL_ADD  = 8'h2C;
  localparam logic [7:0] CTRL_SUB  = 8'hAC;
  localparam logic [7:0] CTRL_AND  = 8'h22;
  localparam logic [7:0] CTRL_OR   = 8'h32;
  localparam logic [7:0] CTRL_XOR  = 8'h04;
  localparam logic [7:0] CTRL_NOT  = 8'h44;
  localparam logic [7:0] CTRL_NAND = 8'h23;
  localparam logic [7:0] CTRL_NOR  = 8'h33;
  localparam logic [7:0] CTRL_XNOR = 8'h05;

`ifdef ALU_ISSUE_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  localparam int CW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
`else
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [REG_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [7:0]           alu_ctrl_q, alu_ctrl_d;
  logic                 alu_cin_q, alu_cin_d;
  logic                 out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0] out_result_q, out_result_d;
  logic                 out_cout_q, out_cout_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_err_q, out_err_d;

`ifdef ALU_ISSUE_MUL_EN
  // The accumulator lives in alu_a_q while multiplying; only the shifting
  // multiplicand/multiplier and the step counter need their own flops.
  logic [REG_WIDTH-1:0] mcand_q, mcand_d, mcand_n;
  logic [REG_WIDTH-1:0] mplier_q, mplier_d, mplier_n;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dec_mul;
`endif

  logic       in_ready;
  logic       accept;
  logic [7:0] dec_ctrl;
  logic       dec_legal;
  logic       dec_swap;
  logic       dec_use_cin;

  // A new request may only enter when idle and the result slot is either
  // empty or being drained in this same cycle.
  assign in_ready = reset_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Opcode decode. SUB swaps operands because the ALU's subtract computes b-a.
  always_comb begin
    dec_ctrl    = 8'h00;
    dec_legal   = 1'b1;
    dec_swap    = 1'b0;
    dec_use_cin = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
    dec_mul     = 1'b0;
`endif
    case (bus.in_op)
      4'h0: dec_ctrl = CTRL_ADD;
      4'h1: begin dec_ctrl = CTRL_ADD; dec_use_cin = 1'b1; end
      4'h2: begin dec_ctrl = CTRL_SUB; dec_swap = 1'b1; end
      4'h3: dec_ctrl = CTRL_AND;
      4'h4: dec_ctrl = CTRL_OR;
      4'h5: dec_ctrl = CTRL_XOR;
      4'h6: dec_ctrl = CTRL_NOT;
      4'h7: dec_ctrl = CTRL_NAND;
      4'h8: dec_ctrl = CTRL_NOR;
      4'h9: dec_ctrl = CTRL_XNOR;
`ifdef ALU_ISSUE_MUL_EN
      4'hA: begin dec_ctrl = CTRL_ADD; dec_mul = 1'b1; end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and register updates. The output slot clears on a drain unless
  // a capture in the same cycle refills it; illegal ops capture straight from
  // IDLE so they skip the ALU cycle entirely.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_cin_d    = alu_cin_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_err_d    = out_err_q;
`ifdef ALU_ISSUE_MUL_EN
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    mcand_n      = mcand_q << 1;
    mplier_n     = mplier_q >> 1;
`endif

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!dec_legal) begin
            out_valid_d  = 1'b1;
            out_result_d = '0;
            out_cout_d   = 1'b0;
            out_zero_d   = 1'b1;
            out_err_d    = 1'b1;
          end
`ifdef ALU_ISSUE_MUL_EN
          else if (dec_mul) begin
            state_d    = MUL;
            alu_a_d    = '0;
            alu_b_d    = bus.in_b[0] ? bus.in_a : '0;
            alu_ctrl_d = dec_ctrl;
            alu_cin_d  = 1'b0;
            mcand_d    = bus.in_a;
            mplier_d   = bus.in_b;
            cnt_d      = '0;
          end
`endif
          else begin
            state_d    = EXEC;
            alu_ctrl_d = dec_ctrl;
            alu_a_d    = dec_swap ? bus.in_b : bus.in_a;
            alu_b_d    = dec_swap ? bus.in_a : bus.in_b;
            alu_cin_d  = dec_use_cin & bus.in_cin;
          end
        end
      end

      EXEC: begin
        out_valid_d  = 1'b1;
        out_result_d = bus.alu_out;
        out_cout_d   = bus.alu_cout;
        out_zero_d   = (bus.alu_out == '0);
        out_err_d    = 1'b0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_ctrl_d   = 8'h00;
        alu_cin_d    = 1'b0;
        state_d      = IDLE;
      end

`ifdef ALU_ISSUE_MUL_EN
      // Each cycle adds the (possibly zero) shifted multiplicand into the
      // accumulator; the final add's sum goes straight into the result slot.
      MUL: begin
        if (cnt_q == CW'(REG_WIDTH - 1)) begin
          out_valid_d  = 1'b1;
          out_result_d = bus.alu_out;
          out_cout_d   = 1'b0;
          out_zero_d   = (bus.alu_out == '0);
          out_err_d    = 1'b0;
          alu_a_d      = '0;
          alu_b_d      = '0;
          alu_ctrl_d   = 8'h00;
          alu_cin_d    = 1'b0;
          state_d      = IDLE;
        end else begin
          alu_a_d  = bus.alu_out;
          alu_b_d  = mplier_n[0] ? mcand_n : '0;
          mcand_d  = mcand_n;
          mplier_d = mplier_n;
          cnt_d    = cnt_q + CW'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 8'h00;
      alu_cin_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_cin_q    <= alu_cin_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
`ifdef ALU_ISSUE_MUL_EN
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq
// Bench for alu_issue_seq: a behavioural ALU answers the control word, and a
// reference model computes each op's result, carry, error flag, control word
// and latency directly from opcode arithmetic. Directed cases are followed by
// randomized ops with random result backpressure and mid-operation resets.
// Honours ALU_ISSUE_MUL_EN the same way as the design.
module tb_alu_issue_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   vecCount  = 0;
  int   missCount = 0;

  always #5 clk = ~clk;

  alu_issue_seq_if #(.REG_WIDTH(W)) bus ();

  alu_issue_seq #(.REG_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural ALU: subtract computes b - a with carry meaning "no borrow".
  logic [W:0] aluSum, aluDiff;
  always_comb begin
    aluSum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
    aluDiff      = {1'b0, bus.alu_b} + {1'b0, ~bus.alu_a} + (W+1)'(1);
    bus.alu_out  = '0;
    bus.alu_cout = 1'b0;
    case (bus.alu_ctrl)
      8'h2C: {bus.alu_cout, bus.alu_out} = aluSum;
      8'hAC: {bus.alu_cout, bus.alu_out} = aluDiff;
      8'h22: bus.alu_out = bus.alu_a & bus.alu_b;
      8'h32: bus.alu_out = bus.alu_a | bus.alu_b;
      8'h04: bus.alu_out = bus.alu_a ^ bus.alu_b;
      8'h44: bus.alu_out = ~bus.alu_a;
      8'h23: bus.alu_out = ~(bus.alu_a & bus.alu_b);
      8'h33: bus.alu_out = ~(bus.alu_a | bus.alu_b);
      8'h05: bus.alu_out = ~(bus.alu_a ^ bus.alu_b);
      default: ;
    endcase
  end

  // Overall time limit so the run can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model. Latency counts clock edges from the accept edge inclusive
  // until out_valid is seen.
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, output logic [W-1:0] res, output logic cout,
                                   output logic err, output int lat, output logic [7:0] ctrl);
    logic [W:0] wide;
    res = '0; cout = 1'b0; err = 1'b0; lat = 2; ctrl = 8'h00; wide = '0;
    case (op)
      4'h0: begin wide = a + b; res = wide[W-1:0]; cout = wide[W]; ctrl = 8'h2C; end
      4'h1: begin wide = a + b + cin; res = wide[W-1:0]; cout = wide[W]; ctrl = 8'h2C; end
      4'h2: begin res = a - b; cout = (a >= b); ctrl = 8'hAC; end
      4'h3: begin res = a & b; ctrl = 8'h22; end
      4'h4: begin res = a | b; ctrl = 8'h32; end
      4'h5: begin res = a ^ b; ctrl = 8'h04; end
      4'h6: begin res = ~a; ctrl = 8'h44; end
      4'h7: begin res = ~(a & b); ctrl = 8'h23; end
      4'h8: begin res = ~(a | b); ctrl = 8'h33; end
      4'h9: begin res = ~(a ^ b); ctrl = 8'h05; end
`ifdef ALU_ISSUE_MUL_EN
      4'hA: begin res = a * b; ctrl = 8'h2C; lat = W + 1; end
`endif
      default: begin err = 1'b1; lat = 1; end
    endcase
  endfunction

  task automatic drainSlot();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("drained", bus.out_valid, 1'b0);
  endtask

  // One transaction: present, wait for accept, check the ALU drive, latency
  // and result, optionally hold the result under backpressure, then drain.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input int hold);
    logic [W-1:0] expRes;
    logic         expCout, expErr;
    int           expLat, lat, waitCnt;
    logic [7:0]   expCtrl;
    refModel(op, a, b, cin, expRes, expCout, expErr, expLat, expCtrl);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
    waitCnt = 0;
    while (!bus.in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op = 4'($urandom); bus.in_a = W'($urandom); bus.in_b = W'($urandom);
    lat = 1;
    if (expLat > 1) begin
      checkOutput("alu_ctrl", bus.alu_ctrl, expCtrl);
      if (expLat == 2) begin
        checkOutput("alu_a", bus.alu_a, (op == 4'h2) ? b : a);
        checkOutput("alu_b", bus.alu_b, (op == 4'h2) ? a : b);
      end
    end
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("result", bus.out_result, expRes);
    checkOutput("cout", bus.out_cout, expCout);
    checkOutput("zero", bus.out_zero, expRes == '0);
    checkOutput("err", bus.out_err, expErr);
    checkOutput("alu_idle", bus.alu_ctrl, 8'h00);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", bus.out_valid, 1'b1);
      checkOutput("hold_result", bus.out_result, expRes);
      checkOutput("hold_ready", bus.in_ready, 1'b0);
    end
    drainSlot();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("rst_ready", bus.in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", bus.out_valid, 1'b0);
    checkOutput("rst_result", bus.out_result, 16'h0000);
    checkOutput("rst_err", bus.out_err, 1'b0);
    checkOutput("rst_ctrl", bus.alu_ctrl, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_ready", bus.in_ready, 1'b1);

    $display("[TB] directed ops");
    applyStimulus(4'h0, 16'hFFFF, 16'h0001, 1'b0, 0);
    applyStimulus(4'h0, 16'h7FFF, 16'h0001, 1'b0, 0);
    applyStimulus(4'h2, 16'h0005, 16'h0003, 1'b0, 0);
    applyStimulus(4'h1, 16'h0001, 16'h0001, 1'b1, 0);
    for (int op = 3; op <= 9; op++) applyStimulus(4'(op), 16'hF0F0, 16'h3C3C, 1'b0, 0);
    applyStimulus(4'hF, 16'h1234, 16'h0000, 1'b0, 0);
    applyStimulus(4'hA, 16'h0012, 16'h0034, 1'b0, 0);

    // Backpressure: second op waits while the slot is full, then enters on
    // the same cycle the slot drains.
    $display("[TB] backpressure");
    applyStimulus(4'h0, 16'h1111, 16'h2222, 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'h0; bus.in_a = 16'h1111; bus.in_b = 16'h2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_op = 4'h5; bus.in_a = 16'hA5A5; bus.in_b = 16'h0FF0;
    checkOutput("bp_first", bus.out_result, 16'h3333);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_ready", bus.in_ready, 1'b0);
      checkOutput("bp_hold", bus.out_result, 16'h3333);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_accept", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checkOutput("bp_drain", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    checkOutput("bp_valid", bus.out_valid, 1'b1);
    checkOutput("bp_second", bus.out_result, 16'hAA55);
    drainSlot();

    $display("[TB] random ops");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)));
    end

    // Reset while an ADD is executing: nothing may come out of it.
    $display("[TB] reset mid-operation");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'h0; bus.in_a = 16'h0001; bus.in_b = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rx_valid", bus.out_valid, 1'b0);
    checkOutput("rx_ctrl", bus.alu_ctrl, 8'h00);
    checkOutput("rx_alu_a", bus.alu_a, 16'h0000);
    checkOutput("rx_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rx_novalid", bus.out_valid, 1'b0);
    end
    checkOutput("rx_ready_after", bus.in_ready, 1'b1);

`ifdef ALU_ISSUE_MUL_EN
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'hA; bus.in_a = 16'h0012; bus.in_b = 16'h0034;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rm_valid", bus.out_valid, 1'b0);
    checkOutput("rm_result", bus.out_result, 16'h0000);
    checkOutput("rm_ctrl", bus.alu_ctrl, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rm_ready", bus.in_ready, 1'b1);
    repeat (W + 2) begin
      @(posedge clk); #1;
      checkOutput("rm_novalid", bus.out_valid, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Issue/sequencing stage directly upstream of the combinational ALU datapath.
- Accepts opcode + operands over a valid/ready handshake and decodes the opcode into the ALU's 8-bit control word.
- Drives the ALU's a/b/ctrl/cin from registers and captures the ALU result and carry into a one-deep output register with its own valid/ready handshake.
- Sequences multi-cycle multiply as repeated ALU adds.

Parameters:
REG_WIDTH, 16, operand/result width; must match the ALU instance.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready at clk rise
in_op  input  4  opcode
in_a  input  REG_WIDTH  operand A
in_b  input  REG_WIDTH  operand B
in_cin  input  1  carry in (ADC only)
alu_a  output  REG_WIDTH  to ALU a
alu_b  output  REG_WIDTH  to ALU b
alu_ctrl  output  8  to ALU ctrl
alu_cin  output  1  to ALU cin
alu_out  input  REG_WIDTH  from ALU out
alu_cout  input  1  from ALU cout
out_valid  output  1  result valid
out_ready  input  1  consumer ready
out_result  output  REG_WIDTH  result
out_cout  output  1  carry out
out_zero  output  1  result == 0
out_err  output  1  illegal opcode

Behaviour:
- Clock and reset: single clock `clk`; asynchronous active-low reset `reset_n`, all flops.
- Reset values: state=IDLE; alu_a/alu_b/alu_ctrl/alu_cin=0; out_valid/out_result/out_cout/out_zero/out_err=0.
- in_ready:
  - in_ready = reset_n & (state==IDLE) & (!out_valid | out_ready). Combinational.
  - in_ready is 0 while reset_n is low.
- Opcodes and ctrl drive (hex):
  - 0 ADD: ctrl 0x2C, cin 0.
  - 1 ADC: ctrl 0x2C, cin=in_cin.
  - 2 SUB (A-B): ctrl 0xAC, alu_a=in_b, alu_b=in_a (operands swapped), cin 0.
  - 3 AND 0x22; 4 OR 0x32; 5 XOR 0x04; 6 NOT-A 0x44; 7 NAND 0x23; 8 NOR 0x33; 9 XNOR 0x05.
  - A MUL (optional feature).
  - B–F illegal.
  - For all non-SUB ops, alu_a=in_a and alu_b=in_b. cin is 0 unless stated.
- States: IDLE, EXEC, MUL.
- IDLE:
  - On accept of a legal non-MUL op: register the ALU drive and go to EXEC.
  - On accept of an illegal op: go directly to result capture with out_result=0, out_cout=0, out_err=1, out_zero=1. out_valid rises the next cycle; no EXEC cycle.
- EXEC (one cycle): at its closing edge, out_result<=alu_out, out_cout<=alu_cout, out_zero<=(alu_out==0), out_err<=0, out_valid<=1; then IDLE.
- Latency: accept at edge k; ALU driven during cycle k..k+1; out_valid high after edge k+1.
- Output slot:
  - out_valid stays high, with data stable, until an out_ready handshake.
  - On a handshake with no new capture, out_valid<=0.
  - Accept and drain in the same cycle is legal; the slot is empty by the time EXEC captures.
- alu_ctrl returns to 0x00, and alu_a/alu_b/alu_cin to 0, on the edge that leaves EXEC/MUL.
- Inputs are ignored when in_ready=0.
- reset_n low mid-operation (EXEC or MUL): immediate return to reset values. The in-flight op is lost, with no partial output.

Optional Feature:
- Macro: ALU_ISSUE_MUL_EN.
- Defined: opcode A is MUL, low REG_WIDTH bits of A*B, shift-add.
  - On accept: acc=0, mcand=in_a, mplier=in_b, counter=0; state MUL.
  - Each MUL cycle: alu_a=acc, alu_b=mplier[0]?mcand:0, ctrl 0x2C, cin 0.
  - At each MUL edge: acc<=alu_out, mcand<<=1, mplier>>=1, counter++.
  - After exactly REG_WIDTH MUL cycles: capture acc as out_result, out_cout=0, zero per result, err=0.
  - Latency REG_WIDTH+1 edges from accept.
- Undefined: opcode A is illegal (result 0, out_err=1); no MUL state or registers synthesised.

Test Plan:
- ADD 0xFFFF+0x0001, then ADD 0x7FFF+0x0001 (bench instantiates real ALU, REG_WIDTH=16):
  - first result 0x0000, cout=1, zero=1; second 0x8000, cout=0, zero=0.
  - Each result valid 2 edges after accept.
- SUB 0x0005-0x0003:
  - alu_a=0x0003, alu_b=0x0005, alu_ctrl=0xAC.
  - result 0x0002, cout=1.
  - ADC 0x0001+0x0001 with cin=1 -> 0x0003.
- Logic ops, A=0xF0F0, B=0x3C3C:
  - AND -> 0x3030; OR -> 0xFCFC; XOR -> 0xCCCC; NOT -> 0x0F0F; NAND -> 0xCFCF; XNOR -> 0x3333.
- Backpressure:
  - out_ready low for 5 cycles: out_result held stable, in_ready=0.
  - Second op presented throughout; accepted on the out_ready cycle; its result follows 2 edges later.
- Illegal op 0xF with A=0x1234 -> result 0x0000, out_err=1, zero=1, valid 1 edge after accept.
- With ALU_ISSUE_MUL_EN: MUL 0x0012*0x0034 -> 0x03A8 after 17 edges.
  - Repeat, asserting reset_n low at MUL cycle 8: all outputs 0; no out_valid; in_ready=1 after release.
